// File: rtl/rx_sequence.sv
// Assembles UART bytes into one ALU command frame: operand A, operand B, control byte.
// Partial frames are dropped on an inter-byte timeout or a UART framing error.
module rx_sequence #(
  parameter int unsigned OPERAND_BYTES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_ready,
  input  logic                       rx_error,
  output logic [8*OPERAND_BYTES-1:0] operand_a,
  output logic [8*OPERAND_BYTES-1:0] operand_b,
  output logic [7:0]                 alu_ctrl,
  output logic                       frame_valid,
  output logic                       timeout_err,
  output logic                       busy,
  output logic [1:0]                 stateID
);

  localparam int unsigned W     = 8 * OPERAND_BYTES;
  localparam int unsigned IDX_W = (OPERAND_BYTES > 1) ? $clog2(OPERAND_BYTES) : 1;
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OPERAND_BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] WAIT_OP1   = 2'd0;
  localparam logic [1:0] WAIT_OP2   = 2'd1;
  localparam logic [1:0] WAIT_CMD   = 2'd2;
  localparam logic [1:0] ST_ILLEGAL = 2'd3;

  logic [1:0]       state, state_n;
  logic [IDX_W-1:0] byte_idx, byte_idx_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic [W-1:0]     shadow_a, shadow_a_n;
  logic [W-1:0]     shadow_b, shadow_b_n;
  logic [W-1:0]     operand_a_n, operand_b_n;
  logic [7:0]       alu_ctrl_n;
  logic             frame_valid_n, timeout_err_n, busy_n;

  assign stateID = state;

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= WAIT_OP1;
      byte_idx    <= '0;
      timer       <= '0;
      shadow_a    <= '0;
      shadow_b    <= '0;
      operand_a   <= '0;
      operand_b   <= '0;
      alu_ctrl    <= '0;
      frame_valid <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      byte_idx    <= byte_idx_n;
      timer       <= timer_n;
      shadow_a    <= shadow_a_n;
      shadow_b    <= shadow_b_n;
      operand_a   <= operand_a_n;
      operand_b   <= operand_b_n;
      alu_ctrl    <= alu_ctrl_n;
      frame_valid <= frame_valid_n;
      timeout_err <= timeout_err_n;
      busy        <= busy_n;
    end
  end

  // Next-state: framing error beats a byte, a byte beats the timeout
  always_comb begin
    state_n       = state;
    byte_idx_n    = byte_idx;
    timer_n       = timer;
    shadow_a_n    = shadow_a;
    shadow_b_n    = shadow_b;
    operand_a_n   = operand_a;
    operand_b_n   = operand_b;
    alu_ctrl_n    = alu_ctrl;
    frame_valid_n = 1'b0;
    timeout_err_n = 1'b0;

    if (state == ST_ILLEGAL || rx_error) begin
      state_n    = WAIT_OP1;
      byte_idx_n = '0;
      timer_n    = '0;
    end else if (rx_ready) begin
      timer_n = '0;
      case (state)
        WAIT_OP1: begin
          shadow_a_n[{byte_idx, 3'b000} +: 8] = rx_data;
          if (byte_idx == LAST_IDX) begin
            byte_idx_n = '0;
            state_n    = WAIT_OP2;
          end else begin
            byte_idx_n = byte_idx + IDX_W'(1);
          end
        end
        WAIT_OP2: begin
          shadow_b_n[{byte_idx, 3'b000} +: 8] = rx_data;
          if (byte_idx == LAST_IDX) begin
            byte_idx_n = '0;
            state_n    = WAIT_CMD;
          end else begin
            byte_idx_n = byte_idx + IDX_W'(1);
          end
        end
        WAIT_CMD: begin
          operand_a_n   = shadow_a;
          operand_b_n   = shadow_b;
          alu_ctrl_n    = rx_data;
          frame_valid_n = 1'b1;
          state_n       = WAIT_OP1;
        end
        default: ;
      endcase
    end else if (busy) begin
      if (timer == TMR_MAX) begin
        state_n       = WAIT_OP1;
        byte_idx_n    = '0;
        timer_n       = '0;
        timeout_err_n = 1'b1;
      end else begin
        timer_n = timer + TMR_W'(1);
      end
    end else begin
      timer_n = '0;
    end

    busy_n = (state_n != WAIT_OP1) || (byte_idx_n != '0);
  end

endmodule

// File: tb/tb_rx_sequence.sv
// Directed bench for rx_sequence: expected frames go into a scoreboard queue as the
// command byte is driven and are popped when frame_valid pulses.
module tb_rx_sequence;

  logic        clock;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        rx_error;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic [7:0]  alu_ctrl;
  logic        frame_valid;
  logic        timeout_err;
  logic        busy;
  logic [1:0]  stateID;

  rx_sequence #(.OPERAND_BYTES(2), .TIMEOUT_CYCLES(20)) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .rx_error    (rx_error),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .alu_ctrl    (alu_ctrl),
    .frame_valid (frame_valid),
    .timeout_err (timeout_err),
    .busy        (busy),
    .stateID     (stateID)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  c;
  } frame_t;

  frame_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_frames = 0;
  int n_timeouts = 0;

  logic [7:0] f1  [5] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'h02};
  logic [1:0] sid1[5] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd0};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic push_frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] c);
    frame_t f;
    f.a = a;
    f.b = b;
    f.c = c;
    exp_q.push_back(f);
  endtask

  // Scoreboard consumer
  always @(negedge clock) begin
    if (reset === 1'b0 && timeout_err === 1'b1) n_timeouts++;
    if (reset === 1'b0 && frame_valid === 1'b1) begin
      frame_t e;
      n_frames++;
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'(frame_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("frame_a", 32'(operand_a), 32'(e.a));
        check("frame_b", 32'(operand_b), 32'(e.b));
        check("frame_ctrl", 32'(alu_ctrl), 32'(e.c));
      end
    end
  end

  initial begin
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_ready = 1'b0;
    rx_error = 1'b0;
    tick();
    tick();
    check("rst_a", 32'(operand_a), 32'd0);
    check("rst_b", 32'(operand_b), 32'd0);
    check("rst_ctrl", 32'(alu_ctrl), 32'd0);
    check("rst_fv", 32'(frame_valid), 32'd0);
    check("rst_to", 32'(timeout_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(stateID), 32'd0);
    reset = 1'b0;
    tick();

    // Test 1: basic frame with 3-clock gaps, stateID walk and strobe timing
    for (int i = 0; i < 5; i++) begin
      if (i == 4) push_frame(16'h1234, 16'h5678, 8'h02);
      send(f1[i], 0);
      check("t1_state", 32'(stateID), 32'(sid1[i]));
      if (i == 4) begin
        check("t1_fv_high", 32'(frame_valid), 32'd1);
        check("t1_busy_idle", 32'(busy), 32'd0);
      end else begin
        check("t1_fv_low", 32'(frame_valid), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        repeat (3) tick();
      end
    end
    tick();
    check("t1_fv_one_cycle", 32'(frame_valid), 32'd0);
    repeat (3) tick();

    // Test 2: back-to-back, next frame's first byte lands in the frame_valid cycle
    for (int i = 0; i < 4; i++) send(f1[i], 0);
    push_frame(16'h1234, 16'h5678, 8'h02);
    send(8'h02, 0);
    check("t2_fv1", 32'(frame_valid), 32'd1);
    push_frame(16'h00FF, 16'h0001, 8'h05);
    send(8'hFF, 0);
    check("t2_busy_after_b0", 32'(busy), 32'd1);
    check("t2_state_after_b0", 32'(stateID), 32'd0);
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'h05, 0);
    check("t2_fv2", 32'(frame_valid), 32'd1);
    repeat (3) tick();

    // Test 3: timeout fires 20 clocks after the last byte, outputs untouched
    send(8'h34, 0);
    send(8'h12, 0);
    send(8'h78, 0);
    repeat (19) tick();
    check("t3_no_early_to", 32'(timeout_err), 32'd0);
    check("t3_busy_before", 32'(busy), 32'd1);
    tick();
    check("t3_to_pulse", 32'(timeout_err), 32'd1);
    check("t3_state", 32'(stateID), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    tick();
    check("t3_to_one_cycle", 32'(timeout_err), 32'd0);
    repeat (4) tick();
    check("t3_hold_a", 32'(operand_a), 32'h00FF);
    check("t3_hold_b", 32'(operand_b), 32'h0001);
    check("t3_hold_ctrl", 32'(alu_ctrl), 32'h05);
    push_frame(16'h0001, 16'h0002, 8'h00);
    send(8'h01, 1); send(8'h00, 1); send(8'h02, 1); send(8'h00, 1); send(8'h00, 2);

    // Test 4: framing error together with a byte discards the partial frame
    send(8'h34, 0);
    send(8'h12, 0);
    rx_error = 1'b1;
    send(8'h78, 0);
    rx_error = 1'b0;
    check("t4_state", 32'(stateID), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_fv", 32'(frame_valid), 32'd0);
    check("t4_to", 32'(timeout_err), 32'd0);
    check("t4_hold_a", 32'(operand_a), 32'h0001);
    push_frame(16'h2211, 16'h4433, 8'h07);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0); send(8'h07, 2);

    // Test 5: reset mid-frame
    send(8'h34, 0);
    send(8'h12, 0);
    send(8'h78, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_a", 32'(operand_a), 32'd0);
    check("t5_b", 32'(operand_b), 32'd0);
    check("t5_ctrl", 32'(alu_ctrl), 32'd0);
    check("t5_state", 32'(stateID), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    push_frame(16'hBBAA, 16'hDDCC, 8'h03);
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0); send(8'h03, 2);

    // Test 6: byte arriving with timer at its last value is accepted
    send(8'h34, 0);
    send(8'h12, 0);
    send(8'h78, 0);
    repeat (19) tick();
    push_frame(16'h1234, 16'h5678, 8'h04);
    send(8'h56, 0);
    check("t6_no_to", 32'(timeout_err), 32'd0);
    check("t6_state", 32'(stateID), 32'd2);
    send(8'h04, 0);
    check("t6_fv", 32'(frame_valid), 32'd1);
    repeat (3) tick();

    check("end_queue_empty", 32'(exp_q.size()), 32'd0);
    check("end_frames", 32'(n_frames), 32'd7);
    check("end_timeouts", 32'(n_timeouts), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
